fila_leitor: RTL and testbench
==============================

Name: fila_leitor

Overview:
- Consumer for the 8-entry `fila` queue; the reader on the other side of its enqueue/dequeue interface.
- Watches the queue's length and head byte, and issues single-cycle dequeue pulses.
- Shifts each popped byte out as an asynchronous serial frame: start bit, 8 data bits LSB-first, stop bit.
- Sits between `fila` and the board's serial/LED output, clocked from the same 10 kHz clock.

Parameters:
- BIT_CYCLES, 4, clock cycles per serial bit (legal range ≥1; 1 is legal).
- DATA_W, 8, width of queue data and shift register.
- LEN_W, 3, width of the queue length input.

Ports:
- clk_10KHz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable_in  input  1  allows starting new frames.
- fila_data_in  input  DATA_W  head of queue (`fila` data_out).
- fila_len_in  input  LEN_W  queue occupancy (`fila` len_out).
- dequeue_out  output  1  one-cycle pop request to `fila` dequeue_in.
- tx_out  output  1  serial line; idles high.
- busy_out  output  1  high in every state except IDLE.
- sent_count_out  output  8  frames fully transmitted, modulo 256.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, dequeue_out=0, tx_out=1, busy_out=0, sent_count_out=0, shift register=0, bit/cycle counters=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, POP, START, DATA, STOP (plus PARITY when the optional feature is on).
- IDLE:
  - On an edge with enable_in=1 and fila_len_in≠0: capture fila_data_in into the shift register, set dequeue_out=1, go to POP.
  - Otherwise stay; tx_out=1.
- POP:
  - Lasts exactly one cycle; dequeue_out is high only in this cycle, and `fila` samples the pop here.
  - Next edge: dequeue_out=0, tx_out=0, cycle counter=0, go to START.
- START: tx_out=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out=shift[bit index] for BIT_CYCLES cycles per bit.
  - Bits go LSB first: index 0..DATA_W-1.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - tx_out=1 for BIT_CYCLES cycles.
  - On the final edge: sent_count_out+1 (255 wraps to 0), go to IDLE.
- Frame timing:
  - Frame = (DATA_W+2)×BIT_CYCLES cycles, measured from the first tx_out=0 cycle.
  - Minimum 1 IDLE cycle between frames; back-to-back pops are therefore spaced (DATA_W+2)×BIT_CYCLES+2 cycles.
- Queue empty (fila_len_in=0): never pulse dequeue_out; stay in IDLE with tx_out=1.
- Queue length changing mid-frame: ignored until IDLE. The queue's len update from the pop is visible by then.
- enable_in dropped mid-frame: the current frame completes; no new pop afterwards.
- fila_data_in changing after capture: no effect on the frame in progress.
- Reset mid-frame: immediate return to reset values. The already-popped byte is lost and is not counted.
- No dequeue is ever issued while busy_out=1.

Optional Feature:
- Macro FILA_LEITOR_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_out = even parity (XOR of the DATA_W data bits) for BIT_CYCLES cycles.
  - Frame = (DATA_W+3)×BIT_CYCLES cycles.
- Undefined: no PARITY state; frame as above; no parity logic synthesized.

Test Plan:
- Reset hold → tx_out=1, dequeue_out=0, busy_out=0, sent_count_out=0 before the first clock edge. Release with fila_len_in=0, enable_in=1 → stays IDLE, no dequeue pulse for 100 cycles.
- fila_len_in=1, fila_data_in=8'hA5, BIT_CYCLES=4 → exactly one 1-cycle dequeue_out pulse, then tx_out sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each, 40 total); sent_count_out=1 afterwards.
- Model `fila` with 8'h11…8'h88 enqueued (len 8) → 8 frames carrying 11,22,…,88 in order; 8 dequeue pulses total; sent_count_out=8; then IDLE with tx_out=1.
- enable_in=0 asserted during DATA of frame 8'h33 → frame completes with correct bits; no further dequeue_out while enable_in=0; resumes on re-enable.
- reset=0 pulsed mid-DATA → tx_out=1 and busy_out=0 immediately (before the next edge); sent_count_out unchanged at 0; next frame starts cleanly after release.
- FILA_LEITOR_PARITY_EN defined, byte 8'h07 → parity bit=1, frame 44 cycles. Byte 8'h03 → parity bit=0.

Source files
------------

// File: rtl/fila_leitor_if.sv
// Queue-side link between `fila` and its reader: head byte, occupancy and
// the single-cycle pop request. The reader (fila_leitor) uses `master`,
// since it is the side that issues the pop requests.
interface fila_leitor_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
);
  logic [DATA_W-1:0] fila_data_in;
  logic [LEN_W-1:0]  fila_len_in;
  logic              dequeue_out;

  modport master (
    input  fila_data_in,
    input  fila_len_in,
    output dequeue_out
  );

  modport slave (
    output fila_data_in,
    output fila_len_in,
    input  dequeue_out
  );
endinterface

// File: rtl/fila_leitor.sv
// fila_leitor: pops bytes from the `fila` queue and shifts each one out as
// an asynchronous serial frame (start, DATA_W bits LSB-first, stop).
// Optional macro FILA_LEITOR_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit.
// All outputs come straight from registers; the FSM is split into a state
// register and a combinational block that computes every next value.
module fila_leitor #(
  parameter int BIT_CYCLES = 4,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 3
) (
  input  logic                 clk_10KHz,
  input  logic                 reset,
  input  logic                 enable_in,
  fila_leitor_if.master        fila,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic [7:0]           sent_count_out
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_DATA,
`ifdef FILA_LEITOR_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              deq_q, deq_d;
  logic              busy_q, busy_d;
  logic [7:0]        sent_q, sent_d;
  logic              bit_end;

  // State and registered outputs; reset returns everything to idle values.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  // Next-state logic. tx_d is the line level for the state being entered,
  // so each bit appears on tx_out exactly when its state begins.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    deq_d   = 1'b0;
    busy_d  = busy_q;
    sent_d  = sent_q;
    bit_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (enable_in && (fila.fila_len_in != '0)) begin
          shift_d = fila.fila_data_in;
          deq_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef FILA_LEITOR_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FILA_LEITOR_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          sent_d  = sent_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign fila.dequeue_out = deq_q;
  assign tx_out           = tx_q;
  assign busy_out         = busy_q;
  assign sent_count_out   = sent_q;

endmodule

// File: tb/tb_fila_leitor.sv
// Bench for fila_leitor: a behavioural `fila` model feeds the reader, every
// enqueued byte is pushed to a scoreboard, and a monitor decodes each serial
// frame against the expected byte. A per-cycle rule check covers when a
// dequeue may and must happen.
`timescale 1ns/1ps
module tb_fila_leitor;

  localparam int BC     = 4;
  localparam int DATA_W = 8;
`ifdef FILA_LEITOR_PARITY_EN
  localparam int NB = DATA_W + 3;
`else
  localparam int NB = DATA_W + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       tx_out;
  logic       busy_out;
  logic [7:0] sent_count_out;

  fila_leitor_if #(.DATA_W(DATA_W), .LEN_W(3)) fif ();

  fila_leitor #(.BIT_CYCLES(BC), .DATA_W(DATA_W), .LEN_W(3)) dut (
    .clk_10KHz      (clk),
    .reset          (rst_n),
    .enable_in      (enable),
    .fila           (fif),
    .tx_out         (tx_out),
    .busy_out       (busy_out),
    .sent_count_out (sent_count_out)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] fq[$];     // contents of the modelled queue
  logic [7:0] exp_q[$];  // bytes expected on the serial line, in order
  logic [7:0] exp_sent = 8'd0;
  logic       mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural queue plus dequeue rule: a pop must occur exactly on the
  // edge after an idle cycle that saw enable and a non-empty queue.
  logic       prev_en = 1'b0, prev_busy = 1'b0, prev_rst = 1'b0, exp_deq;
  logic [2:0] prev_len = 3'd0;
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      exp_deq = prev_en && (prev_len != 3'd0) && !prev_busy;
      chk("dequeue_rule", fif.dequeue_out, exp_deq);
    end
    if (rst_n && fif.dequeue_out && fq.size() > 0) void'(fq.pop_front());
    // 3-bit length cannot encode 8; only emptiness matters to the reader
    fif.fila_len_in  = (fq.size() > 7) ? 3'd7 : 3'(fq.size());
    fif.fila_data_in = (fq.size() > 0) ? fq[0] : 8'h00;
    prev_en   = enable;
    prev_len  = fif.fila_len_in;
    prev_busy = busy_out;
    prev_rst  = rst_n;
  end

  // Frame monitor: on each pop, decode the following frame cycle by cycle.
  logic [7:0] mb;
  logic       frame_bits [NB];
  logic       ok, abort;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_sent = 8'd0;
        continue;
      end
      if (fif.dequeue_out) begin
        mon_busy = 1'b1;
        abort    = 1'b0;
        chk("pop_cycle_tx", tx_out, 1);
        chk("pop_cycle_busy", busy_out, 1);
        chk("dequeue_has_expected_byte", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          frame_bits[0] = 1'b0;
          for (int i = 0; i < DATA_W; i++) frame_bits[1 + i] = mb[i];
`ifdef FILA_LEITOR_PARITY_EN
          frame_bits[DATA_W + 1] = ^mb;
`endif
          frame_bits[NB - 1] = 1'b1;
          for (int k = 0; k < NB && !abort; k++) begin
            ok = 1'b1;
            for (int c = 0; c < BC; c++) begin
              @(negedge clk);
              if (!rst_n) begin
                abort = 1'b1;
                break;
              end
              if (tx_out !== frame_bits[k] || busy_out !== 1'b1) ok = 1'b0;
            end
            if (!abort) chk($sformatf("frame_%02h_bit%0d_ok", mb, k), ok, 1);
          end
          if (!abort) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
            else begin
              exp_sent = exp_sent + 8'd1;
              chk("post_frame_busy", busy_out, 0);
              chk("post_frame_tx", tx_out, 1);
              chk("sent_count", sent_count_out, exp_sent);
            end
          end
          if (abort) exp_sent = 8'd0;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_deq(input int budget);
    int n = 0;
    while (!fif.dequeue_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dequeue_seen_in_time", fif.dequeue_out, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || mon_busy || busy_out) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained_in_time", n < budget, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned pushed;
    rst_n  = 1'b1;
    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_tx", tx_out, 1);
    chk("reset_deq", fif.dequeue_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_sent", sent_count_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // empty queue: must idle with the line high
    repeat (100) @(posedge clk);
    #1;
    chk("empty_idle_tx", tx_out, 1);
    chk("empty_idle_busy", busy_out, 0);

    // single byte, then the parity-sensitive bytes
    push(8'hA5);
    wait_idle(200);
    chk("sent_after_a5", sent_count_out, 1);
    push(8'h07);
    push(8'h03);
    wait_idle(400);

    // full queue of eight bytes
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    wait_idle(1000);
    chk("sent_after_burst", sent_count_out, 11);
    chk("idle_tx_after_burst", tx_out, 1);

    // enable dropped mid-DATA: frame finishes, no further pop until re-enable
    push(8'h33);
    push(8'h44);
    wait_deq(50);
    @(posedge clk);
    repeat (BC * 4) @(posedge clk);
    #1 enable = 1'b0;
    for (int n = 0; n < 200 && (mon_busy || exp_q.size() > 1); n++) begin
      @(posedge clk); #1;
    end
    repeat (150) @(posedge clk);
    #1;
    chk("byte_held_while_disabled", fq.size(), 1);
    enable = 1'b1;
    wait_idle(200);

    // reset mid-DATA: immediate idle values, byte lost, count cleared
    push(8'h5A);
    wait_deq(50);
    @(posedge clk);
    repeat (BC * 5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx", tx_out, 1);
    chk("midreset_busy", busy_out, 0);
    chk("midreset_deq", fif.dequeue_out, 0);
    chk("midreset_sent", sent_count_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("lost_byte_gone", exp_q.size(), 0);
    push(8'hC3);
    wait_idle(200);
    chk("sent_after_reset_frame", sent_count_out, 1);

    // random traffic with enable toggling; long enough to wrap the count
    pushed = 0;
    for (int cyc = 0; cyc < 40000 && pushed < 260; cyc++) begin
      @(posedge clk); #1;
      if (fq.size() < 8 && $urandom_range(0, 29) == 0) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    enable = 1'b1;
    wait_idle(2000);
    chk("random_all_pushed", pushed, 260);
    chk("sent_wrapped", sent_count_out, 8'(261));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
